// File: rtl/alu_accum_seq_if.sv
// alu_accum_seq_if: request/response bundle between the CPU control FSM
// (master) and the sequential ALU/accumulator (slave).
//   start/opcode/data/acc_wr : request, sampled by the ALU only when idle
//   busy/done                : handshake status
//   alu_out/accum/zero/carry/ovf : result, accumulator and flags
interface alu_accum_seq_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
);
  logic             start;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] data;
  logic             acc_wr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] accum;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output start, opcode, data, acc_wr,
    input  busy, done, alu_out, accum, zero, carry, ovf
  );
  modport slave (
    input  start, opcode, data, acc_wr,
    output busy, done, alu_out, accum, zero, carry, ovf
  );
endinterface

// File: rtl/alu_accum_seq.sv
// alu_accum_seq: sequential ALU + accumulator with start/busy/done handshake.
//   clk1 : clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : alu_accum_seq_if.slave (request in, result/flags/status out)
// Single-cycle ops complete one edge after start; MUL runs WIDTH shift-add
// iterations and completes WIDTH edges after start. done pulses one cycle.
module alu_accum_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic          clk1,
  input  logic          rst,
  alu_accum_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ANDD = OPW'(3);
  localparam logic [OPW-1:0] OP_XORR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA  = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(10);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(11);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t             r_state, w_next;
  logic [OPW-1:0]     r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, r_alu;
  logic               r_wr, r_c, r_v, r_done;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_last, w_fin;
  logic [WIDTH:0]     w_add, w_sub, w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_fin  = (r_state == S_EXEC) || ((r_state == S_MUL) && w_last);

  // Width+1 sums: the top bit is carry-out for ADD and borrow for SUB.
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  // One shift-add step: low half of r_prod holds the remaining multiplier
  // bits, high half accumulates; add multiplicand when the current bit is 1.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};

  always_ff @(posedge clk1) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      S_MUL:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result/flag selection; unlisted opcodes pass accum and keep flags.
  always_comb begin
    w_res = r_a;
    w_c   = r_c;
    w_v   = r_v;
    case (r_op)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_add[MSB] != r_a[MSB]);
      end
      OP_ANDD: begin w_res = r_a & r_b; w_c = 1'b0; w_v = 1'b0; end
      OP_XORR: begin w_res = r_a ^ r_b; w_c = 1'b0; w_v = 1'b0; end
      OP_LDA:  begin w_res = r_b;       w_c = 1'b0; w_v = 1'b0; end
      OP_SUB: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);
      end
      OP_MUL: begin
        w_res = w_prod_nxt[MSB:0];
        w_c   = |w_prod_nxt[2*WIDTH-1:WIDTH];
        w_v   = |w_prod_nxt[2*WIDTH-1:WIDTH];
      end
      OP_SHL: begin w_res = {r_a[MSB-1:0], 1'b0}; w_c = r_a[MSB]; w_v = 1'b0; end
      OP_SHR: begin w_res = {1'b0, r_a[MSB:1]};   w_c = r_a[0];   w_v = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_wr   <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_alu  <= '0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && bus.start) begin
        r_op   <= bus.opcode;
        r_a    <= r_acc;
        r_b    <= bus.data;
        r_wr   <= bus.acc_wr;
        r_cnt  <= '0;
        r_prod <= {{WIDTH{1'b0}}, bus.data};
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_fin) begin
        r_alu  <= w_res;
        r_c    <= w_c;
        r_v    <= w_v;
        r_done <= 1'b1;
        if (r_wr) r_acc <= w_res;
      end
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.alu_out = r_alu;
  assign bus.accum   = r_acc;
  assign bus.zero    = (r_acc == '0);
  assign bus.carry   = r_c;
  assign bus.ovf     = r_v;
endmodule
